vend_disp_ctrl: RTL
===================

// Module: vend_disp_ctrl
// PURPOSE
//  Sequences the physical dispense hardware behind the vending FSM.
//  - Queues vend events (drink/snack + quarters of change).
//  - Drives one shared actuator path: item solenoid, then one coin-ejector kick per quarter.
//  - Checks each ejected quarter against the coin sensor; detects jams.
// PARAMETERS
//  PULSE_CYC   4   cycles each solenoid / coin_kick pulse stays high (>=1)
//  GAP_CYC     2   idle cycles after every pulse before the next action (>=1)
//  ACK_TO      16  max cycles in WAIT_ACK without coin_ack before a jam is declared
//  FIFO_DEPTH  4   event queue depth, power of 2 (>=2)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  ev_drink   in   1  1-cycle pulse: drink sold
//  ev_snack   in   1  1-cycle pulse: snack sold
//  ev_chg     in   3  quarters of change owed; valid with ev_drink/ev_snack
//  coin_ack   in   1  coin sensor: high >=1 cycle per quarter passed
//  clr_err    in   1  clears jam_err and resumes from JAM
//  sol_drink  out  1  drink solenoid drive
//  sol_snack  out  1  snack solenoid drive
//  coin_kick  out  1  coin ejector drive
//  busy       out  1  FSM not IDLE, or FIFO not empty
//  q_full     out  1  FIFO holds FIFO_DEPTH entries
//  ovf_err    out  1  1-cycle pulse: event dropped because FIFO full
//  jam_err    out  1  sticky: quarter not acknowledged within ACK_TO
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM=IDLE, counters 0. All outputs registered.
//  - Push: at edge E with ev_drink|ev_snack, write {item, ev_chg}.
//    - Both strobes high: item=drink; snack is dropped, no error.
//  - Full FIFO: push ignored, ovf_err=1 for one cycle.
//    - If a pop happens at the same edge, the push is accepted and ovf_err stays 0.
//  - No bypass: push and pop of the same entry never share an edge.
//  - FSM states: IDLE, VEND, VGAP, KICK, WAIT_ACK, KGAP, JAM.
//  - IDLE:
//    - FIFO non-empty at an edge: pop, load item and chg_rem=chg, go to VEND.
//    - An event sampled at E into an empty FIFO: sol_* high from edge E+1.
//  - VEND: matching sol_* high exactly PULSE_CYC cycles -> VGAP.
//  - VGAP: GAP_CYC cycles, all drives low.
//    - Then chg_rem==0 -> IDLE, else -> KICK.
//  - KICK: coin_kick high exactly PULSE_CYC cycles -> WAIT_ACK.
//    - A coin_ack seen during KICK is latched and counts as the acknowledgement.
//  - WAIT_ACK: timer counts cycles.
//    - ack latched or coin_ack=1 -> chg_rem-1, clear latch, KGAP.
//    - Timer reaches ACK_TO with no ack -> JAM, jam_err=1.
//  - KGAP: GAP_CYC cycles low, then chg_rem==0 -> IDLE, else -> KICK.
//  - JAM: all drives low; FIFO still accepts pushes.
//    - clr_err -> jam_err=0, go to KICK and retry the same quarter; chg_rem unchanged.
//  - clr_err outside JAM: clears jam_err only (no-op if already 0).
//  - coin_ack outside KICK/WAIT_ACK: ignored.
//  - ev_chg 0..7 accepted as-is; chg=0 skips the kick phase.
//  - Reset mid-operation: immediate return to reset state. Queued events and pending change are lost.
// CONFIGURATION
//  - VEND_DISP_CNT_EN defined: adds output coin_total [15:0].
//    - +1 on each acknowledged quarter; saturates at 16'hFFFF; reset 0.
//  - VEND_DISP_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - ev_drink, ev_chg=1, ack 2 cycles into WAIT_ACK
//    -> sol_drink high 4 cyc, 2 low, coin_kick high 4 cyc; IDLE, busy=0.
//  - ev_snack, ev_chg=3, ack each quarter
//    -> sol_snack 4 cyc, 3 coin_kick pulses; coin_total=3 with VEND_DISP_CNT_EN.
//  - 6 events on 6 consecutive cycles
//    -> 1st popped, 4 queued, q_full=1; 6th gives ovf_err pulse; 5 events served in order.
//  - ev_drink, ev_chg=2, no ack
//    -> jam_err=1 after 16 WAIT_ACK cycles, drives low.
//    -> clr_err -> retry kick; ack; 2nd quarter still served.
//  - rst_n low during KICK with 2 events queued
//    -> all outputs 0 immediately; after release busy=0, no further pulses.
//  - ev_drink and ev_snack same cycle, ev_chg=0
//    -> only sol_drink pulses 4 cyc, no coin_kick, ovf_err=0.

Source files
------------

// File: rtl/vend_disp_ctrl.sv
// Dispense sequencer: event FIFO, solenoid pulse, coin-kick loop with jam detection.
// Optional VEND_DISP_CNT_EN adds a saturating coin_total output.
module vend_disp_ctrl #(
    parameter int PULSE_CYC  = 4,
    parameter int GAP_CYC    = 2,
    parameter int ACK_TO     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ev_drink,
    input  logic        ev_snack,
    input  logic [2:0]  ev_chg,
    input  logic        coin_ack,
    input  logic        clr_err,
    output logic        sol_drink,
    output logic        sol_snack,
    output logic        coin_kick,
    output logic        busy,
    output logic        q_full,
    output logic        ovf_err,
    output logic        jam_err
`ifdef VEND_DISP_CNT_EN
   ,output logic [15:0] coin_total
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int M1   = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int MAXC = (ACK_TO > M1) ? ACK_TO : M1;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] A_LAST = CW'(ACK_TO - 1);
    localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, VEND, VGAP, KICK, WAIT_ACK, KGAP, JAM
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          item_q, item_d;
    logic [2:0]    chg_q, chg_d;
    logic          lat_q, lat_d;
    logic          jam_q, jam_d;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fcnt_q, fcnt_d;

    logic          sold_q, sols_q, kick_q, busy_q, full_q, ovf_q;

    logic          ev, pop, push, full, ovf_d;
    logic [3:0]    head;

    // Pop only in IDLE on an existing entry, so a same-edge push never bypasses.
    always_comb begin
        ev     = ev_drink | ev_snack;
        full   = (fcnt_q == DEPTH);
        pop    = (state_q == IDLE) && (fcnt_q != '0);
        push   = ev && (!full || pop);
        ovf_d  = ev && full && !pop;
        fcnt_d = fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        head   = mem_q[rd_q];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        item_d  = item_q;
        chg_d   = chg_q;
        lat_d   = lat_q;
        jam_d   = jam_q;
        if (clr_err) jam_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = VEND;
                    item_d  = head[3];
                    chg_d   = head[2:0];
                    cnt_d   = '0;
                end
            end
            VEND: begin
                if (cnt_q == P_LAST) begin
                    state_d = VGAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VGAP, KGAP: begin
                if (cnt_q == G_LAST) begin
                    state_d = (chg_q == 3'd0) ? IDLE : KICK;
                    cnt_d   = '0;
                    lat_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KICK: begin
                if (coin_ack) lat_d = 1'b1;
                if (cnt_q == P_LAST) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (lat_q || coin_ack) begin
                    state_d = KGAP;
                    chg_d   = chg_q - 3'd1;
                    lat_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == A_LAST) begin
                    state_d = JAM;
                    jam_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            JAM: begin
                if (clr_err) begin
                    state_d = KICK;
                    cnt_d   = '0;
                    lat_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            item_q  <= 1'b0;
            chg_q   <= '0;
            lat_q   <= 1'b0;
            jam_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
            sold_q  <= 1'b0;
            sols_q  <= 1'b0;
            kick_q  <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            item_q  <= item_d;
            chg_q   <= chg_d;
            lat_q   <= lat_d;
            jam_q   <= jam_d;
            fcnt_q  <= fcnt_d;
            if (push) begin
                mem_q[wr_q] <= {ev_snack & ~ev_drink, ev_chg};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            // Drives follow the next state so they switch on the same edge.
            sold_q <= (state_d == VEND) && !item_d;
            sols_q <= (state_d == VEND) && item_d;
            kick_q <= (state_d == KICK);
            busy_q <= (state_d != IDLE) || (fcnt_d != '0);
            full_q <= (fcnt_d == DEPTH);
            ovf_q  <= ovf_d;
        end
    end

`ifdef VEND_DISP_CNT_EN
    logic [15:0] total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (state_q == WAIT_ACK && state_d == KGAP
                     && total_q != 16'hFFFF) begin
            total_q <= total_q + 16'd1;
        end
    end

    assign coin_total = total_q;
`endif

    assign sol_drink = sold_q;
    assign sol_snack = sols_q;
    assign coin_kick = kick_q;
    assign busy      = busy_q;
    assign q_full    = full_q;
    assign ovf_err   = ovf_q;
    assign jam_err   = jam_q;

endmodule
